// File: rtl/i2c_codec_pkg.sv
// Shared types and constants for the audio codec I2C register-interface model.
// States and register indices match the codec's 3-byte write protocol.
package i2c_codec_pkg;

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE
  } i2cState_t;

  // Latched write request: {reg_addr, 9-bit data}
  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
  } wrReq_t;

  localparam logic [6:0] DEF_DEV_ADDR = 7'h1A;
  localparam logic [6:0] RESET_REG    = 7'h0F;

  localparam logic [3:0] LIN_L  = 4'd0;
  localparam logic [3:0] LIN_R  = 4'd1;
  localparam logic [3:0] HEAD_L = 4'd2;
  localparam logic [3:0] HEAD_R = 4'd3;
  localparam logic [3:0] APATH  = 4'd4;
  localparam logic [3:0] DPATH  = 4'd5;
  localparam logic [3:0] PWR    = 4'd6;
  localparam logic [3:0] FORMAT = 4'd7;
  localparam logic [3:0] SAMPLE = 4'd8;
  localparam logic [3:0] ACTIVE = 4'd9;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into iCLK and detects SCL edges plus START/STOP.
// Latency: SYNC_STAGES+1 cycles from pin to event pulse.
// Backpressure: none; events are single-cycle pulses.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic sclIn,
  input  logic sdaIn,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] sclSync;
  logic [SYNC_STAGES-1:0] sdaSync;
  logic                   sclD;
  logic                   sdaD;
  logic                   sclS;

  // Preset to 1 so reset looks like an idle bus and produces no false START
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sclSync <= '1;
      sdaSync <= '1;
      sclD    <= 1'b1;
      sdaD    <= 1'b1;
    end else begin
      sclSync <= {sclSync[SYNC_STAGES-2:0], sclIn};
      sdaSync <= {sdaSync[SYNC_STAGES-2:0], sdaIn};
      sclD    <= sclSync[SYNC_STAGES-1];
      sdaD    <= sdaSync[SYNC_STAGES-1];
    end
  end

  assign sclS      = sclSync[SYNC_STAGES-1];
  assign sda_s     = sdaSync[SYNC_STAGES-1];
  assign scl_rise  = sclS & ~sclD;
  assign scl_fall  = ~sclS & sclD;
  assign start_det = sclS & sclD & sdaD & ~sda_s;
  assign stop_det  = sclS & sclD & ~sdaD & sda_s;

endmodule

// File: rtl/i2c_codec_slave.sv
// I2C write-only slave modelling the audio codec register file (3-byte writes).
// Latency: commit one cycle after ACK_2 entry, strobe registered; read port 1 cycle.
// Backpressure: none; every addressed byte of a write is ACKed, extra bytes NACKed.
module i2c_codec_slave
  import i2c_codec_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEF_DEV_ADDR,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  input  logic [3:0] iRD_ADDR,
  output logic [8:0] oRD_DATA,
  output logic       oWR_STROBE,
  output logic [6:0] oWR_ADDR,
  output logic [8:0] oWR_DATA,
  output logic       oBUSY,
  output logic       oBAD_ADDR
);

  localparam int         AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NUM_REGW = 8'(NUM_REGS);

  i2cState_t  state, stateNext;
  logic [3:0] bitCnt;
  logic [7:0] shiftReg;
  wrReq_t     req;
  logic       sdaDriveLow, sdaNext;
  logic       latchHi, latchLo;
  logic       commitPend;
  logic [8:0] regFile [NUM_REGS];
  logic       sclRise, sclFall, startDet, stopDet, sdaS;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) uSync (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .sclIn     (I2C_SCLK),
    .sdaIn     (I2C_SDAT),
    .scl_rise  (sclRise),
    .scl_fall  (sclFall),
    .start_det (startDet),
    .stop_det  (stopDet),
    .sda_s     (sdaS)
  );

  // Reset gates the drive so SDA is released in the cycle reset is applied
  assign I2C_SDAT = (sdaDriveLow && !iRST) ? 1'b0 : 1'bz;

  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    sdaNext   = sdaDriveLow;
    latchHi   = 1'b0;
    latchLo   = 1'b0;
    if (startDet) begin
      stateNext = ADDR;
      sdaNext   = 1'b0;
    end else if (stopDet) begin
      stateNext = IDLE;
      sdaNext   = 1'b0;
    end else if (sclFall) begin
      case (state)
        ADDR: if (bitCnt == 4'd8) begin
          if (shiftReg == {DEV_ADDR, 1'b0}) begin
            stateNext = ACK_A;
            sdaNext   = 1'b1;
          end else begin
            stateNext = IGNORE;
          end
        end
        ACK_A: begin
          stateNext = BYTE1;
          sdaNext   = 1'b0;
        end
        BYTE1: if (bitCnt == 4'd8) begin
          stateNext = ACK_1;
          sdaNext   = 1'b1;
          latchHi   = 1'b1;
        end
        ACK_1: begin
          stateNext = BYTE2;
          sdaNext   = 1'b0;
        end
        BYTE2: if (bitCnt == 4'd8) begin
          stateNext = ACK_2;
          sdaNext   = 1'b1;
          latchLo   = 1'b1;
        end
        ACK_2: begin
          stateNext = IGNORE;
          sdaNext   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sdaDriveLow <= 1'b0;
      bitCnt      <= '0;
      shiftReg    <= '0;
      req         <= '0;
      commitPend  <= 1'b0;
      oBUSY       <= 1'b0;
    end else begin
      sdaDriveLow <= sdaNext;
      commitPend  <= (stateNext == ACK_2) && (state != ACK_2);
      if (startDet) oBUSY <= 1'b1;
      else if (stopDet) oBUSY <= 1'b0;
      // Every state change (and any START) begins a fresh byte
      if (startDet || stateNext != state) begin
        bitCnt   <= '0;
        shiftReg <= '0;
      end else if (sclRise && bitCnt != 4'd8 &&
                   (state == ADDR || state == BYTE1 || state == BYTE2)) begin
        bitCnt   <= bitCnt + 4'd1;
        shiftReg <= {shiftReg[6:0], sdaS};
      end
      if (latchHi) req <= {shiftReg, 8'h00};
      if (latchLo) req.data[7:0] <= shiftReg;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      regFile    <= '{default: '0};
      oRD_DATA   <= '0;
      oWR_STROBE <= 1'b0;
      oWR_ADDR   <= '0;
      oWR_DATA   <= '0;
      oBAD_ADDR  <= 1'b0;
    end else begin
      oWR_STROBE <= 1'b0;
      oBAD_ADDR  <= 1'b0;
      if (commitPend) begin
        if (req.addr == RESET_REG && req.data == 9'd0) begin
          regFile    <= '{default: '0};
          oWR_STROBE <= 1'b1;
          oWR_ADDR   <= req.addr;
          oWR_DATA   <= req.data;
        end else if ({1'b0, req.addr} < NUM_REGW) begin
          regFile[req.addr[AW-1:0]] <= req.data;
          oWR_STROBE <= 1'b1;
          oWR_ADDR   <= req.addr;
          oWR_DATA   <= req.data;
        end else begin
          oBAD_ADDR <= 1'b1;
        end
      end
      oRD_DATA <= ({4'b0, iRD_ADDR} < NUM_REGW) ? regFile[iRD_ADDR[AW-1:0]] : 9'd0;
    end
  end

endmodule

// File: tb/tb_i2c_codec_slave.sv
// Bus-model master driving directed I2C writes; a monitor scores commit events.
module tb_i2c_codec_slave;

  typedef struct {
    logic       bad;
    logic [6:0] addr;
    logic [8:0] data;
  } evt_t;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       sclLine = 1'b1;
  logic       mstLow = 1'b0;
  logic [3:0] iRD_ADDR = '0;
  wire        sdaBus;
  logic [8:0] oRD_DATA;
  logic       oWR_STROBE;
  logic [6:0] oWR_ADDR;
  logic [8:0] oWR_DATA;
  logic       oBUSY;
  logic       oBAD_ADDR;

  int   checks = 0;
  int   errors = 0;
  evt_t expQ[$];
  logic ackBit;

  assign sdaBus = mstLow ? 1'b0 : 1'bz;
  pullup (sdaBus);

  always #10 iCLK = ~iCLK;

  i2c_codec_slave dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .I2C_SCLK   (sclLine),
    .I2C_SDAT   (sdaBus),
    .iRD_ADDR   (iRD_ADDR),
    .oRD_DATA   (oRD_DATA),
    .oWR_STROBE (oWR_STROBE),
    .oWR_ADDR   (oWR_ADDR),
    .oWR_DATA   (oWR_DATA),
    .oBUSY      (oBUSY),
    .oBAD_ADDR  (oBAD_ADDR)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic expectEvt(input logic bad, input logic [6:0] a, input logic [8:0] d);
    evt_t e;
    e.bad = bad; e.addr = a; e.data = d;
    expQ.push_back(e);
  endtask

  task automatic startCond();
    mstLow = 1'b0;  tick(10);
    sclLine = 1'b1; tick(10);
    mstLow = 1'b1;  tick(10);
    sclLine = 1'b0; tick(10);
  endtask

  task automatic stopCond();
    mstLow = 1'b1;  tick(10);
    sclLine = 1'b1; tick(10);
    mstLow = 1'b0;  tick(10);
  endtask

  task automatic sendBits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      mstLow = ~b[i]; tick(10);
      sclLine = 1'b1; tick(10);
      sclLine = 1'b0;
    end
  endtask

  task automatic ackSlot(output logic ack);
    tick(10);
    mstLow = 1'b0;  tick(10);
    sclLine = 1'b1; tick(5);
    ack = sdaBus;   tick(5);
    sclLine = 1'b0; tick(10);
  endtask

  task automatic writeByte(input logic [7:0] b, input logic expAck, input string name);
    logic a;
    sendBits(b);
    ackSlot(a);
    chk(name, {31'd0, a}, {31'd0, expAck});
  endtask

  task automatic readReg(input logic [3:0] idx, input logic [8:0] exp, input string name);
    iRD_ADDR = idx;
    tick(1);
    chk(name, {23'd0, oRD_DATA}, {23'd0, exp});
  endtask

  // Monitor: every commit event must match the head of the expectation queue
  initial begin
    evt_t e;
    forever begin
      @(negedge iCLK);
      if (oWR_STROBE || oBAD_ADDR) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event strobe=%0b bad=%0b addr=%h data=%h",
                   oWR_STROBE, oBAD_ADDR, oWR_ADDR, oWR_DATA);
        end else begin
          e = expQ.pop_front();
          if (e.bad !== oBAD_ADDR || e.bad === oWR_STROBE ||
              (!e.bad && (oWR_ADDR !== e.addr || oWR_DATA !== e.data))) begin
            errors++;
            $display("FAIL commit_event got strobe=%0b bad=%0b addr=%h data=%h want bad=%0b addr=%h data=%h",
                     oWR_STROBE, oBAD_ADDR, oWR_ADDR, oWR_DATA, e.bad, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(5);
    chk("rst_busy",   {31'd0, oBUSY},      32'd0);
    chk("rst_strobe", {31'd0, oWR_STROBE}, 32'd0);
    chk("rst_bad",    {31'd0, oBAD_ADDR},  32'd0);
    chk("rst_wraddr", {25'd0, oWR_ADDR},   32'd0);
    chk("rst_wrdata", {23'd0, oWR_DATA},   32'd0);
    chk("rst_rddata", {23'd0, oRD_DATA},   32'd0);
    chk("rst_sda",    {31'd0, sdaBus},     32'd1);
    iRST = 1'b0;
    tick(20);

    // Full write to reg 7
    expectEvt(1'b0, 7'h07, 9'h001);
    startCond();
    chk("t1_busy", {31'd0, oBUSY}, 32'd1);
    writeByte(8'h34, 1'b0, "t1_ack_addr");
    writeByte(8'h0E, 1'b0, "t1_ack_b1");
    writeByte(8'h01, 1'b0, "t1_ack_b2");
    stopCond();
    readReg(4'd7, 9'h001, "t1_reg7");
    chk("t1_busy_after", {31'd0, oBUSY}, 32'd0);

    // Wrong device address: nothing is acknowledged
    startCond();
    writeByte(8'h36, 1'b1, "t2_nack_addr");
    writeByte(8'h0E, 1'b1, "t2_nack_b1");
    writeByte(8'h01, 1'b1, "t2_nack_b2");
    stopCond();
    chk("t2_busy_after", {31'd0, oBUSY}, 32'd0);
    readReg(4'd7, 9'h001, "t2_reg7");

    // Aborted write is discarded, following write lands
    startCond();
    writeByte(8'h34, 1'b0, "t4_ack_addr");
    writeByte(8'h0E, 1'b0, "t4_ack_b1");
    stopCond();
    readReg(4'd7, 9'h001, "t4_reg7");
    expectEvt(1'b0, 7'h09, 9'h001);
    startCond();
    writeByte(8'h34, 1'b0, "t4_ack_addr2");
    writeByte(8'h12, 1'b0, "t4_ack_b1_2");
    writeByte(8'h01, 1'b0, "t4_ack_b2_2");
    stopCond();
    readReg(4'd9, 9'h001, "t4_reg9");

    // Write reg 4, then the codec reset command clears everything
    expectEvt(1'b0, 7'h04, 9'h0F8);
    startCond();
    writeByte(8'h34, 1'b0, "t3_ack_addr");
    writeByte(8'h08, 1'b0, "t3_ack_b1");
    writeByte(8'hF8, 1'b0, "t3_ack_b2");
    stopCond();
    readReg(4'd4, 9'h0F8, "t3_reg4");
    expectEvt(1'b0, 7'h0F, 9'h000);
    startCond();
    writeByte(8'h34, 1'b0, "t3_ack_addr2");
    writeByte(8'h1E, 1'b0, "t3_ack_b1_2");
    writeByte(8'h00, 1'b0, "t3_ack_b2_2");
    stopCond();
    for (int r = 0; r < 16; r++) readReg(4'(r), 9'h000, $sformatf("t3_clear_reg%0d", r));

    // Repeated START after a complete write, then a NACKed 4th byte
    expectEvt(1'b0, 7'h01, 9'h0AA);
    expectEvt(1'b0, 7'h02, 9'h07B);
    startCond();
    writeByte(8'h34, 1'b0, "t5_ack_addr");
    writeByte(8'h02, 1'b0, "t5_ack_b1");
    writeByte(8'hAA, 1'b0, "t5_ack_b2");
    startCond();
    writeByte(8'h34, 1'b0, "t5_ack_addr2");
    writeByte(8'h04, 1'b0, "t5_ack_b1_2");
    writeByte(8'h7B, 1'b0, "t5_ack_b2_2");
    writeByte(8'h55, 1'b1, "t5_nack_b4");
    stopCond();
    readReg(4'd1, 9'h0AA, "t5_reg1");
    readReg(4'd2, 9'h07B, "t5_reg2");

    // Out-of-range register: ACKed, flagged, not written
    expectEvt(1'b1, 7'h20, 9'h055);
    startCond();
    writeByte(8'h34, 1'b0, "t6_ack_addr");
    writeByte(8'h40, 1'b0, "t6_ack_b1");
    writeByte(8'h55, 1'b0, "t6_ack_b2");
    stopCond();
    readReg(4'd0, 9'h000, "t6_reg0");

    // Reset while the slave is pulling SDA low for an ACK
    startCond();
    sendBits(8'h34);
    tick(10);
    mstLow = 1'b0;
    tick(2);
    chk("t6_sda_acking", {31'd0, sdaBus}, 32'd0);
    chk("t6_busy_pre",   {31'd0, oBUSY},  32'd1);
    iRST = 1'b1;
    #1;
    chk("t6_sda_released", {31'd0, sdaBus}, 32'd1);
    tick(1);
    chk("t6_busy_reset", {31'd0, oBUSY}, 32'd0);
    tick(3);
    iRST = 1'b0;
    tick(10);
    stopCond();
    tick(20);
    chk("pending_events", expQ.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
